// File: rtl/call_pkg.sv
// Shared constants and helpers for the call/cancel button conditioner.
// Defaults assume a 100 MHz clk and a 10 ms debounce window.
package call_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_SYNC_STAGES     = 2;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: synchroniser, debounce counter, stable level and
// a single-cycle pulse on each accepted press.
module debounce_channel
  import call_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   stable_q;
  logic                   stable_d;
  logic                   pulse_q;
  logic                   pulse_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any sample matching the stable level restarts the window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync;
        pulse_d  = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level = stable_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/call_button_conditioner.sv
// Conditions the passenger-panel call and cancel buttons into
// clean debounced levels and one-cycle press pulses.
module call_button_conditioner
  import call_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic call_btn_raw,
  input  logic cancel_btn_raw,
  output logic call_pulse,
  output logic cancel_pulse,
  output logic call_level,
  output logic cancel_level
);

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_call (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (call_btn_raw),
    .level   (call_level),
    .pulse   (call_pulse)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_cancel (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (cancel_btn_raw),
    .level   (cancel_level),
    .pulse   (cancel_pulse)
  );

endmodule

// File: tb/tb_call_button_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses/levels by edge
// number, a single monitor pops and compares them.
module tb_call_button_conditioner;

  typedef struct {
    int e;
    bit c;
    bit k;
  } pev_t;

  typedef struct {
    int e;
    int id;
    bit v;
  } lev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic call_raw, cancel_raw;
  logic call_pulse, cancel_pulse;
  logic call_level, cancel_level;
  logic g_raw, g_cancel_raw;
  logic g_pulse, g_cancel_pulse;
  logic g_level, g_cancel_level;

  int   edge_n = 0;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;
  int   e;

  pev_t pq[$];
  pev_t gq[$];
  lev_t lq[$];

  call_button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .call_btn_raw   (call_raw),
    .cancel_btn_raw (cancel_raw),
    .call_pulse     (call_pulse),
    .cancel_pulse   (cancel_pulse),
    .call_level     (call_level),
    .cancel_level   (cancel_level)
  );

  call_button_conditioner #(
    .DEBOUNCE_CYCLES (1),
    .SYNC_STAGES     (2)
  ) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .call_btn_raw   (g_raw),
    .cancel_btn_raw (g_cancel_raw),
    .call_pulse     (g_pulse),
    .cancel_pulse   (g_cancel_pulse),
    .call_level     (g_level),
    .cancel_level   (g_cancel_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void exp_p(int ee, bit c, bit k);
    pq.push_back('{ee, c, k});
  endfunction

  function automatic void exp_g(int ee);
    gq.push_back('{ee, 1'b1, 1'b0});
  endfunction

  function automatic void exp_l(int ee, int id, bit v);
    lq.push_back('{ee, id, v});
  endfunction

  function automatic logic lev_of(int id);
    case (id)
      0:       return call_level;
      1:       return cancel_level;
      default: return g_level;
    endcase
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: the only process that compares and counts.
  always begin
    pev_t ev;
    lev_t lv;
    logic got;
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      total++;
      if ({call_pulse, cancel_pulse, call_level, cancel_level,
           g_pulse, g_cancel_pulse, g_level, g_cancel_level}
          !== 8'h00) begin
        bad++;
        $display("FAIL reset_outs t=%0t got=%b%b%b%b%b%b%b%b exp=0",
                 $time, call_pulse, cancel_pulse, call_level,
                 cancel_level, g_pulse, g_cancel_pulse, g_level,
                 g_cancel_level);
      end
    end else begin
      if (call_pulse || cancel_pulse) begin
        total++;
        if (pq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse edge=%0d got c=%b k=%b exp none",
                   edge_n, call_pulse, cancel_pulse);
        end else begin
          ev = pq.pop_front();
          if (ev.e != edge_n || ev.c != call_pulse ||
              ev.k != cancel_pulse) begin
            bad++;
            $display("FAIL pulse got edge=%0d c=%b k=%b exp edge=%0d c=%b k=%b",
                     edge_n, call_pulse, cancel_pulse, ev.e, ev.c, ev.k);
          end
        end
      end
      if (g_pulse || g_cancel_pulse) begin
        total++;
        if (gq.size() == 0 || g_cancel_pulse) begin
          bad++;
          $display("FAIL n1_unexpected_pulse edge=%0d got p=%b cp=%b",
                   edge_n, g_pulse, g_cancel_pulse);
        end else begin
          ev = gq.pop_front();
          if (ev.e != edge_n) begin
            bad++;
            $display("FAIL n1_pulse got edge=%0d exp edge=%0d",
                     edge_n, ev.e);
          end
        end
      end
      while (lq.size() > 0 && lq[0].e <= edge_n) begin
        lv  = lq.pop_front();
        got = lev_of(lv.id);
        total++;
        if (lv.e != edge_n || got !== lv.v) begin
          bad++;
          $display("FAIL level%0d edge=%0d got=%b exp=%b at edge %0d",
                   lv.id, edge_n, got, lv.v, lv.e);
        end
      end
    end
    if (done) begin
      total++;
      if (pq.size() != 0 || gq.size() != 0 || lq.size() != 0) begin
        bad++;
        $display("FAIL missing_events got pq=%0d gq=%0d lq=%0d exp 0",
                 pq.size(), gq.size(), lq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    call_raw     = 1'b0;
    cancel_raw   = 1'b0;
    g_raw        = 1'b0;
    g_cancel_raw = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(3);

    // clean press, held 20
    call_raw = 1'b1;
    e = edge_n + 1;
    exp_p(e + 5, 1'b1, 1'b0);
    exp_l(e + 4, 0, 1'b0);
    exp_l(e + 5, 0, 1'b1);
    exp_l(e + 19, 1, 1'b0);
    step(20);
    call_raw = 1'b0;
    step(10);

    // bounce: runs of 3 never accepted
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 8; i++) begin
        call_raw = (i == 3 || i == 7) ? 1'b0 : 1'b1;
        step(1);
      end
    end
    exp_l(edge_n + 1, 0, 1'b0);
    call_raw = 1'b1;
    e = edge_n + 1;
    exp_p(e + 5, 1'b1, 1'b0);
    exp_l(e + 5, 0, 1'b1);
    step(6);
    call_raw = 1'b0;
    step(10);

    // release and re-press
    call_raw = 1'b1;
    e = edge_n + 1;
    exp_p(e + 5, 1'b1, 1'b0);
    step(10);
    call_raw = 1'b0;
    e = edge_n + 1;
    exp_l(e + 4, 0, 1'b1);
    exp_l(e + 5, 0, 1'b0);
    step(10);
    call_raw = 1'b1;
    e = edge_n + 1;
    exp_p(e + 5, 1'b1, 1'b0);
    step(10);
    call_raw = 1'b0;
    step(10);

    // simultaneous press
    call_raw   = 1'b1;
    cancel_raw = 1'b1;
    e = edge_n + 1;
    exp_p(e + 5, 1'b1, 1'b1);
    exp_l(e + 5, 1, 1'b1);
    step(8);
    call_raw   = 1'b0;
    cancel_raw = 1'b0;
    step(10);

    // reset mid-count with cancel already accepted
    cancel_raw = 1'b1;
    e = edge_n + 1;
    exp_p(e + 5, 1'b0, 1'b1);
    exp_l(e + 5, 1, 1'b1);
    step(8);
    call_raw = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    e = edge_n + 1;
    exp_p(e + 5, 1'b1, 1'b1);
    step(10);
    call_raw   = 1'b0;
    cancel_raw = 1'b0;
    step(10);

    // DEBOUNCE_CYCLES=1: press then one-cycle glitch
    g_raw = 1'b1;
    e = edge_n + 1;
    exp_g(e + 2);
    exp_l(e + 1, 2, 1'b0);
    exp_l(e + 2, 2, 1'b1);
    step(5);
    g_raw = 1'b0;
    step(5);
    g_raw = 1'b1;
    e = edge_n + 1;
    exp_g(e + 2);
    exp_l(e + 2, 2, 1'b1);
    exp_l(e + 3, 2, 1'b0);
    step(1);
    g_raw = 1'b0;
    step(6);

    done = 1'b1;
  end

endmodule
